// File: rtl/ahb_pkg.sv
// Purpose: shared AHB-Lite encodings and the default-slave state type.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // ERR1/ERR2 form the mandatory two-cycle ERROR response
   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Purpose: default slave for unmapped accesses: two-cycle ERROR response plus error log.
// Latency: response starts the cycle after the capturing edge; log updates on that same edge.
// Backpressure: inserts exactly one wait state (ERR1) per unmapped NONSEQ/SEQ transfer.
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        capture,
   input  logic        unmapped,
   input  logic        trans_active,
   input  logic [31:0] haddr,
   input  logic        err_clr,
   output logic        hready,
   output logic        hresp,
   output logic [15:0] err_count,
   output logic [31:0] err_addr
);

   ds_state_t state;
   logic      new_err;

   assign new_err = capture & unmapped & trans_active;

   // Response FSM; hready/hresp are registered alongside the state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= DS_IDLE;
         hready <= 1'b1;
         hresp  <= HRESP_OKAY;
      end else begin
         case (state)
            DS_ERR1: begin
               state  <= DS_ERR2;
               hready <= 1'b1;
               hresp  <= HRESP_ERROR;
            end
            default: begin
               // IDLE and ERR2 both accept the next address phase when it is captured
               if (capture) begin
                  if (new_err) begin
                     state  <= DS_ERR1;
                     hready <= 1'b0;
                     hresp  <= HRESP_ERROR;
                  end else begin
                     state  <= DS_IDLE;
                     hready <= 1'b1;
                     hresp  <= HRESP_OKAY;
                  end
               end
            end
         endcase
      end
   end

   // Error log: a new error beats a clear, so a clear never loses a fresh error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count <= 16'h0000;
         err_addr  <= 32'h0000_0000;
      end else if (new_err) begin
         err_addr <= haddr;
         if (err_clr) begin
            err_count <= 16'h0001;
         end else if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'h0001;
         end
      end else if (err_clr) begin
         err_count <= 16'h0000;
         err_addr  <= 32'h0000_0000;
      end
   end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Purpose: single-master AHB-Lite decoder, data-phase slave mux and built-in default slave.
// Latency: HSEL_S combinational from HADDR; data-phase outputs follow the selected slave with no added delay.
// Backpressure: HREADY is the selected slave's HREADYOUT (or default-slave ready); sel_q holds while HREADY=0.
module ahb_lite_interconnect
   import ahb_pkg::*;
#(
   parameter int                       NUM_SLAVES    = 4,
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE    = {32'h5200_0000, 32'h5100_0000,
                                                        32'h5000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK    = {NUM_SLAVES{32'hFF00_0000}},
   parameter logic [31:0]              DEFAULT_RDATA = 32'hDEAD_BEEF
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic [31:0]                HADDR,
   input  logic [1:0]                 HTRANS,
   output logic [NUM_SLAVES-1:0]      HSEL_S,
   input  logic [NUM_SLAVES*32-1:0]   HRDATA_S,
   input  logic [NUM_SLAVES-1:0]      HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]      HRESP_S,
   output logic [31:0]                HRDATA,
   output logic                       HREADY,
   output logic                       HRESP,
   input  logic                       ERR_CLR,
   output logic [15:0]                ERR_COUNT,
   output logic [31:0]                ERR_ADDR
);

   localparam int            SW          = $clog2(NUM_SLAVES + 1);
   localparam logic [SW-1:0] SEL_DEFAULT = SW'(NUM_SLAVES);

   logic [SW-1:0] hit_idx;
   logic          hit_any;
   logic [SW-1:0] sel_q;
   logic          dtrans_q;
   logic          ds_hready;
   logic          ds_hresp;
   logic          unused_htrans0;

   // HTRANS[0] only separates BUSY from IDLE and SEQ from NONSEQ, which routing ignores
   assign unused_htrans0 = HTRANS[0];

   // Address decode; scanning downward lets the lowest matching index win overlaps
   always_comb begin
      hit_idx = SEL_DEFAULT;
      hit_any = 1'b0;
      HSEL_S  = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (((HADDR ^ SLAVE_BASE[i*32 +: 32]) & SLAVE_MASK[i*32 +: 32]) == 32'h0000_0000) begin
            hit_idx   = SW'(i);
            hit_any   = 1'b1;
            HSEL_S    = '0;
            HSEL_S[i] = 1'b1;
         end
      end
   end

   // Data-phase select register, advanced only when the bus is ready
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         sel_q    <= SEL_DEFAULT;
         dtrans_q <= 1'b0;
      end else if (HREADY) begin
         sel_q    <= hit_idx;
         dtrans_q <= HTRANS[1];
      end
   end

   ahb_default_slave u_ds (
      .clk          (HCLK),
      .rst_n        (HRESETn),
      .capture      (HREADY),
      .unmapped     (~hit_any),
      .trans_active (HTRANS[1]),
      .haddr        (HADDR),
      .err_clr      (ERR_CLR),
      .hready       (ds_hready),
      .hresp        (ds_hresp),
      .err_count    (ERR_COUNT),
      .err_addr     (ERR_ADDR)
   );

   // Data-phase mux; an IDLE/BUSY data phase on the default slave is always zero-wait OKAY
   always_comb begin
      HRDATA = DEFAULT_RDATA;
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      if (sel_q == SEL_DEFAULT) begin
         if (dtrans_q) begin
            HREADY = ds_hready;
            HRESP  = ds_hresp;
         end
      end else begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SW'(i)) begin
               HRDATA = HRDATA_S[i*32 +: 32];
               HREADY = HREADYOUT_S[i];
               HRESP  = HRESP_S[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Purpose: randomized and directed check of ahb_lite_interconnect against a transfer-level model.
// Latency: model tracks the current data phase and how many cycles it has lasted.
// Backpressure: slave HREADYOUT values are driven randomly to exercise wait states.
module tb_ahb_lite_interconnect;
   import ahb_pkg::*;

   localparam int NS = 4;

   logic           HCLK = 1'b0;
   logic           HRESETn;
   logic [31:0]    HADDR;
   logic [1:0]     HTRANS;
   logic [NS-1:0]  HSEL_S;
   logic [NS*32-1:0] HRDATA_S;
   logic [NS-1:0]  HREADYOUT_S;
   logic [NS-1:0]  HRESP_S;
   logic [31:0]    HRDATA;
   logic           HREADY;
   logic           HRESP;
   logic           ERR_CLR;
   logic [15:0]    ERR_COUNT;
   logic [31:0]    ERR_ADDR;

   logic [NS-1:0]  hsel_ovl;
   logic [31:0]    rdata_ovl;
   logic           ready_ovl;
   logic           resp_ovl;
   logic [15:0]    cnt_ovl;
   logic [31:0]    eaddr_ovl;

   // slave-side stimulus: nx_* set by the sequence, s_* applied after the falling edge
   logic [31:0] nx_rdata [NS];
   logic        nx_rdy   [NS];
   logic        nx_rsp   [NS];
   logic [31:0] s_rdata  [NS];
   logic        s_rdy    [NS];
   logic        s_rsp    [NS];

   // behavioural model: current data phase target (-1 = default), active flag, cycles elapsed
   int          m_slave;
   bit          m_active;
   int          m_cyc;
   logic [15:0] m_cnt;
   logic [31:0] m_eaddr;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 HCLK = ~HCLK;

   always_comb begin
      HRDATA_S    = '0;
      HREADYOUT_S = '0;
      HRESP_S     = '0;
      for (int i = 0; i < NS; i++) begin
         HRDATA_S[i*32 +: 32] = s_rdata[i];
         HREADYOUT_S[i]       = s_rdy[i];
         HRESP_S[i]           = s_rsp[i];
      end
   end

   ahb_lite_interconnect u_dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSEL_S      (HSEL_S),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .ERR_CLR     (ERR_CLR),
      .ERR_COUNT   (ERR_COUNT),
      .ERR_ADDR    (ERR_ADDR)
   );

   // second instance whose slaves 0 and 1 both claim 0x50xx_xxxx
   ahb_lite_interconnect #(
      .SLAVE_BASE ({32'h5200_0000, 32'h5100_0000, 32'h5000_0000, 32'h5000_0000})
   ) u_ovl (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSEL_S      (hsel_ovl),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HRDATA      (rdata_ovl),
      .HREADY      (ready_ovl),
      .HRESP       (resp_ovl),
      .ERR_CLR     (ERR_CLR),
      .ERR_COUNT   (cnt_ovl),
      .ERR_ADDR    (eaddr_ovl)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // region map of the default parameters, expressed as top-byte ownership
   function automatic int ref_decode(input logic [31:0] a);
      logic [7:0] owner [NS];
      owner = '{8'h00, 8'h50, 8'h51, 8'h52};
      for (int i = 0; i < NS; i++)
         if (a[31:24] == owner[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_slave  = -1;
      m_active = 1'b0;
      m_cyc    = 0;
      m_cnt    = 16'h0000;
      m_eaddr  = 32'h0;
   endtask

   // one bus cycle: drive, compare against the model, then apply the rising-edge effect
   task automatic step(input logic [31:0] addr, input logic [1:0] trans,
                       input logic clr, input logic rst, input string tag);
      int          d;
      logic [3:0]  e_hsel;
      logic [31:0] e_rdata;
      logic        e_rdy;
      logic        e_rsp;
      @(negedge HCLK);
      HADDR   = addr;
      HTRANS  = trans;
      ERR_CLR = clr;
      HRESETn = !rst;
      for (int i = 0; i < NS; i++) begin
         s_rdata[i] = nx_rdata[i];
         s_rdy[i]   = nx_rdy[i];
         s_rsp[i]   = nx_rsp[i];
      end
      #1;
      d      = ref_decode(addr);
      e_hsel = (d < 0) ? 4'b0000 : 4'(1 << d);
      if (m_slave >= 0) begin
         e_rdata = s_rdata[m_slave];
         e_rdy   = s_rdy[m_slave];
         e_rsp   = s_rsp[m_slave];
      end else begin
         e_rdata = 32'hDEAD_BEEF;
         e_rdy   = !(m_active && m_cyc == 0);
         e_rsp   = m_active;
      end
      chk({tag, ".hsel"},   32'(HSEL_S),    32'(e_hsel));
      chk({tag, ".hrdata"}, HRDATA,         e_rdata);
      chk({tag, ".hready"}, 32'(HREADY),    32'(e_rdy));
      chk({tag, ".hresp"},  32'(HRESP),     32'(e_rsp));
      chk({tag, ".errcnt"}, 32'(ERR_COUNT), 32'(m_cnt));
      chk({tag, ".erradr"}, ERR_ADDR,       m_eaddr);
      if (rst) begin
         model_reset();
      end else if (e_rdy) begin
         if (d < 0 && trans[1]) begin
            m_eaddr = addr;
            if (clr) m_cnt = 16'h0001;
            else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
         end else if (clr) begin
            m_cnt   = 16'h0000;
            m_eaddr = 32'h0;
         end
         m_slave  = d;
         m_active = trans[1];
         m_cyc    = 0;
      end else begin
         if (clr) begin
            m_cnt   = 16'h0000;
            m_eaddr = 32'h0;
         end
         m_cyc++;
      end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         nx_rdata[i] = 32'h1000_0000 + i;
         nx_rdy[i]   = 1'b1;
         nx_rsp[i]   = 1'b0;
         s_rdata[i]  = nx_rdata[i];
         s_rdy[i]    = 1'b1;
         s_rsp[i]    = 1'b0;
      end
      HRESETn = 1'b0;
      HADDR   = 32'h0;
      HTRANS  = HTRANS_IDLE;
      ERR_CLR = 1'b0;
      repeat (3) @(posedge HCLK);
      model_reset();

      // reset state
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "rst");
      chk("rst.hready_c", 32'(HREADY), 32'd1);
      chk("rst.hrdata_c", HRDATA, 32'hDEAD_BEEF);

      // mapped read through slave 1
      nx_rdata[1] = 32'h1234_5678;
      step(32'h5000_0010, HTRANS_NONSEQ, 0, 0, "map.a");
      chk("map.hsel_c", 32'(HSEL_S), 32'h2);
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "map.d");
      chk("map.rdata_c", HRDATA, 32'h1234_5678);

      // slave 0 inserts three wait states while slave 2 is addressed
      step(32'h0000_0100, HTRANS_NONSEQ, 0, 0, "ws.a");
      nx_rdy[0]   = 1'b0;
      nx_rdata[0] = 32'h0000_0A0A;
      nx_rdata[2] = 32'hA5A5_0002;
      for (int k = 0; k < 3; k++) begin
         step(32'h5100_0000, HTRANS_NONSEQ, 0, 0, "ws.w");
         chk("ws.hready_c", 32'(HREADY), 32'd0);
         chk("ws.rdata_c", HRDATA, 32'h0000_0A0A);
      end
      nx_rdy[0] = 1'b1;
      step(32'h5100_0000, HTRANS_NONSEQ, 0, 0, "ws.r");
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "ws.d");
      chk("ws.rdata2_c", HRDATA, 32'hA5A5_0002);

      // unmapped NONSEQ: two-cycle ERROR
      step(32'h9000_0000, HTRANS_NONSEQ, 0, 0, "err.a");
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "err.1");
      chk("err1.hready_c", 32'(HREADY), 32'd0);
      chk("err1.hresp_c", 32'(HRESP), 32'd1);
      chk("err1.cnt_c", 32'(ERR_COUNT), 32'd1);
      chk("err1.addr_c", ERR_ADDR, 32'h9000_0000);
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "err.2");
      chk("err2.hready_c", 32'(HREADY), 32'd1);
      chk("err2.hresp_c", 32'(HRESP), 32'd1);

      // unmapped IDLE is zero-wait OKAY
      step(32'h9000_0000, HTRANS_IDLE, 0, 0, "idl.a");
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "idl.d");
      chk("idl.hresp_c", 32'(HRESP), 32'd0);
      chk("idl.cnt_c", 32'(ERR_COUNT), 32'd1);

      // back-to-back unmapped transfers after a clear
      step(32'h0000_0000, HTRANS_IDLE, 1, 0, "b2b.clr");
      step(32'h9000_0004, HTRANS_NONSEQ, 0, 0, "b2b.a");
      step(32'h9000_0008, HTRANS_SEQ, 0, 0, "b2b.e1");
      step(32'h9000_0008, HTRANS_SEQ, 0, 0, "b2b.e2");
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "b2b.e3");
      chk("b2b.e3_hready_c", 32'(HREADY), 32'd0);
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "b2b.e4");
      chk("b2b.cnt_c", 32'(ERR_COUNT), 32'd2);

      // saturation: preload 0xFFFE, then three more errors
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "sat.pre");
      force u_dut.u_ds.err_count = 16'hFFFE;
      m_cnt = 16'hFFFE;
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "sat.frc");
      release u_dut.u_ds.err_count;
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "sat.rel");
      step(32'h9000_0000, HTRANS_NONSEQ, 0, 0, "sat.1");
      step(32'h9000_0010, HTRANS_NONSEQ, 0, 0, "sat.2");
      step(32'h9000_0010, HTRANS_NONSEQ, 0, 0, "sat.3");
      step(32'h9000_0020, HTRANS_NONSEQ, 0, 0, "sat.4");
      step(32'h9000_0020, HTRANS_NONSEQ, 0, 0, "sat.5");
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "sat.6");
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "sat.7");
      chk("sat.cnt_c", 32'(ERR_COUNT), 32'h0000_FFFF);
      chk("sat.addr_c", ERR_ADDR, 32'h9000_0020);
      step(32'h9100_0000, HTRANS_NONSEQ, 1, 0, "clr.a");
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "clr.1");
      chk("clr.cnt_c", 32'(ERR_COUNT), 32'd1);
      chk("clr.addr_c", ERR_ADDR, 32'h9100_0000);
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "clr.2");

      // overlapping regions: lowest index wins
      step(32'h5000_0000, HTRANS_IDLE, 0, 0, "ovl.a");
      chk("ovl.hsel_c", 32'(hsel_ovl), 32'h1);
      step(32'h5200_0040, HTRANS_IDLE, 0, 0, "ovl.b");
      chk("ovl.hsel2_c", 32'(hsel_ovl), 32'h8);

      // reset asserted during ERR1
      step(32'h9000_0000, HTRANS_NONSEQ, 0, 0, "rse.a");
      step(32'h0000_0000, HTRANS_IDLE, 0, 1, "rse.1");
      chk("rse.err1_c", 32'(HREADY), 32'd0);
      step(32'h0000_0000, HTRANS_IDLE, 0, 0, "rse.2");
      chk("rse.hready_c", 32'(HREADY), 32'd1);
      chk("rse.hresp_c", 32'(HRESP), 32'd0);
      chk("rse.cnt_c", 32'(ERR_COUNT), 32'd0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         logic [7:0]  tops [6];
         logic [31:0] a;
         tops = '{8'h00, 8'h50, 8'h51, 8'h52, 8'h90, 8'hA0};
         a = {tops[$urandom_range(5)], 24'($urandom)};
         for (int i = 0; i < NS; i++) begin
            nx_rdata[i] = $urandom;
            nx_rdy[i]   = ($urandom_range(3) != 0);
            nx_rsp[i]   = ($urandom_range(7) == 0);
         end
         step(a, 2'($urandom_range(3)), ($urandom_range(19) == 0),
              ($urandom_range(99) == 0), "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
